// File: rtl/fir_tdm_pkg.sv
// Shared types and helpers for the time-multiplexed FIR: FSM states, width
// functions and the Q-format round/saturate used on the accumulator.
package fir_tdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic        ovf;
    logic [63:0] val;
  } rs_t;

  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int tap_w(input int order);
    return $clog2(order);
  endfunction

  function automatic int acc_w(input int word_len, input int order);
    return 2 * word_len + $clog2(order);
  endfunction

  // Round half-up, drop frac_bits, then clamp to a word_len-bit signed range.
  function automatic rs_t round_sat(input logic signed [63:0] acc,
                                    input int frac_bits,
                                    input int word_len);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rs_t                res;
    r       = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
    hi      = (64'sd1 <<< (word_len - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (word_len - 1));
    res.ovf = 1'b0;
    res.val = r;
    if (r > hi) begin
      res.val = hi;
      res.ovf = 1'b1;
    end else if (r < lo) begin
      res.val = lo;
      res.ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_tdm_filter_if.sv
// Sample, coefficient-load and result signals of the TDM FIR grouped as one bundle.
interface fir_tdm_filter_if
  import fir_tdm_pkg::*;
#(
  parameter int WORD_LENGTH  = 16,
  parameter int FILTER_ORDER = 32,
  parameter int CHANNELS     = 2
);
  localparam int CH_W  = ch_w(CHANNELS);
  localparam int TAP_W = tap_w(FILTER_ORDER);

  logic                          enable;
  logic                          in_valid;
  logic                          in_ready;
  logic [CH_W-1:0]               in_channel;
  logic signed [WORD_LENGTH-1:0] DataInput;
  logic                          coef_we;
  logic [TAP_W-1:0]              coef_addr;
  logic signed [WORD_LENGTH-1:0] coef_data;
  logic                          coef_commit;
  logic                          commit_pending;
  logic                          out_valid;
  logic [CH_W-1:0]               out_channel;
  logic signed [WORD_LENGTH-1:0] DataOutput;
  logic                          overflow;

  modport master (
    output enable, in_valid, in_channel, DataInput,
    output coef_we, coef_addr, coef_data, coef_commit,
    input  in_ready, commit_pending, out_valid, out_channel, DataOutput, overflow
  );

  modport slave (
    input  enable, in_valid, in_channel, DataInput,
    input  coef_we, coef_addr, coef_data, coef_commit,
    output in_ready, commit_pending, out_valid, out_channel, DataOutput, overflow
  );
endinterface

// File: rtl/fir_mac_unit.sv
// Single signed multiply-accumulate with clear/enable; the accumulator is
// presented through the shared round/saturate stage.
module fir_mac_unit
  import fir_tdm_pkg::*;
#(
  parameter int WORD_LENGTH  = 16,
  parameter int FILTER_ORDER = 32,
  parameter int FRAC_BITS    = 15
) (
  input  logic                          clk,
  input  logic                          i_en,
  input  logic                          i_clr,
  input  logic                          i_acc,
  input  logic signed [WORD_LENGTH-1:0] i_coef,
  input  logic signed [WORD_LENGTH-1:0] i_sample,
  output logic signed [WORD_LENGTH-1:0] o_result,
  output logic                          o_overflow
);
  localparam int ACC_W = acc_w(WORD_LENGTH, FILTER_ORDER);

  logic signed [2*WORD_LENGTH-1:0] w_prod_p0;
  logic signed [ACC_W-1:0]         r_acc_p1;
  rs_t                             w_rs;
  logic                            w_unused_hi;

  assign w_prod_p0 = (2*WORD_LENGTH)'(i_coef) * (2*WORD_LENGTH)'(i_sample);

  // p0 -> p1: accumulate; cleared when a new sample starts
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_clr) begin
        r_acc_p1 <= '0;
      end else if (i_acc) begin
        r_acc_p1 <= r_acc_p1 + ACC_W'(w_prod_p0);
      end
    end
  end

  assign w_rs        = round_sat({{(64-ACC_W){r_acc_p1[ACC_W-1]}}, r_acc_p1}, FRAC_BITS, WORD_LENGTH);
  assign o_result    = w_rs.val[WORD_LENGTH-1:0];
  assign o_overflow  = w_rs.ovf;
  assign w_unused_hi = ^w_rs.val[63:WORD_LENGTH];

endmodule

// File: rtl/fir_tdm_filter.sv
// Multi-channel FIR sharing one MAC across channels: per-channel circular
// delay lines, double-buffered coefficients, IDLE/MAC/OUT sequencing.
module fir_tdm_filter
  import fir_tdm_pkg::*;
#(
  parameter int WORD_LENGTH  = 16,
  parameter int FILTER_ORDER = 32,
  parameter int CHANNELS     = 2,
  parameter int FRAC_BITS    = 15
) (
  input logic             clk,
  input logic             reset,
  fir_tdm_filter_if.slave bus
);
  localparam int               CH_W     = ch_w(CHANNELS);
  localparam int               TAP_W    = tap_w(FILTER_ORDER);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(FILTER_ORDER - 1);

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [TAP_W-1:0]              r_k;
  logic [CH_W-1:0]               r_ch;
  logic [TAP_W-1:0]              r_head     [CHANNELS];
  logic signed [WORD_LENGTH-1:0] r_dline    [CHANNELS][FILTER_ORDER];
  logic signed [WORD_LENGTH-1:0] r_coef_act [FILTER_ORDER];
  logic signed [WORD_LENGTH-1:0] r_coef_sh  [FILTER_ORDER];
  logic signed [WORD_LENGTH-1:0] w_coef_sh_nxt [FILTER_ORDER];
  logic                          r_commit_pending;

  logic                          w_ch_ok;
  logic                          w_start;
  logic                          w_commit_now;
  logic                          w_mac_clr;
  logic                          w_mac_acc;
  logic                          w_out_valid;
  logic                          w_ovf;
  logic [TAP_W-1:0]              w_head;
  logic [TAP_W-1:0]              w_rd_idx;
  logic signed [WORD_LENGTH-1:0] w_coef;
  logic signed [WORD_LENGTH-1:0] w_sample;
  logic signed [WORD_LENGTH-1:0] w_result;

  // Out-of-range channels are still handshaken but never start a computation.
  assign w_ch_ok      = ({1'b0, bus.in_channel} < (CH_W+1)'(CHANNELS));
  assign w_start      = (r_state == ST_IDLE) && bus.enable && bus.in_valid && w_ch_ok;
  assign w_commit_now = (r_state == ST_IDLE) && (r_commit_pending || bus.coef_commit);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else if (bus.enable) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_MAC;
      ST_MAC:  if (r_k == LAST_TAP) w_state_nxt = ST_OUT;
      ST_OUT:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_out_valid        = (r_state == ST_OUT) && bus.enable && !reset;
    w_mac_clr          = w_start;
    w_mac_acc          = (r_state == ST_MAC);
    bus.in_ready       = (r_state == ST_IDLE) && bus.enable && !reset;
    bus.out_valid      = w_out_valid;
    bus.out_channel    = w_out_valid ? r_ch : '0;
    bus.DataOutput     = w_out_valid ? w_result : '0;
    bus.overflow       = w_out_valid && w_ovf;
    bus.commit_pending = r_commit_pending;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k  <= '0;
      r_ch <= '0;
    end else if (bus.enable) begin
      if (w_start) begin
        r_k  <= '0;
        r_ch <= bus.in_channel;
      end else if (r_state == ST_MAC) begin
        r_k <= r_k + TAP_W'(1);
      end
    end
  end

  // Tap k reads x[n-k] at (head - k) mod FILTER_ORDER.
  assign w_head   = r_head[r_ch];
  assign w_rd_idx = (w_head >= r_k) ? (w_head - r_k) : (w_head + TAP_W'(FILTER_ORDER) - r_k);
  assign w_sample = r_dline[r_ch][w_rd_idx];
  assign w_coef   = r_coef_act[r_k];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_head[c] <= '0;
        for (int t = 0; t < FILTER_ORDER; t++) r_dline[c][t] <= '0;
      end
    end else if (bus.enable) begin
      if (w_start) begin
        r_dline[bus.in_channel][r_head[bus.in_channel]] <= bus.DataInput;
      end
      if (r_state == ST_OUT) begin
        r_head[r_ch] <= (r_head[r_ch] == LAST_TAP) ? '0 : r_head[r_ch] + TAP_W'(1);
      end
    end
  end

  // Same-cycle write is merged before a commit copies the shadow bank.
  always_comb begin
    w_coef_sh_nxt = r_coef_sh;
    if (bus.coef_we) w_coef_sh_nxt[bus.coef_addr] = bus.coef_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_commit_pending <= 1'b0;
      for (int t = 0; t < FILTER_ORDER; t++) begin
        r_coef_sh[t]  <= '0;
        r_coef_act[t] <= '0;
      end
    end else if (bus.enable) begin
      for (int t = 0; t < FILTER_ORDER; t++) r_coef_sh[t] <= w_coef_sh_nxt[t];
      if (w_commit_now) begin
        r_commit_pending <= 1'b0;
        for (int t = 0; t < FILTER_ORDER; t++) r_coef_act[t] <= w_coef_sh_nxt[t];
      end else if (bus.coef_commit) begin
        r_commit_pending <= 1'b1;
      end
    end
  end

  fir_mac_unit #(
    .WORD_LENGTH (WORD_LENGTH),
    .FILTER_ORDER(FILTER_ORDER),
    .FRAC_BITS   (FRAC_BITS)
  ) u_mac (
    .clk       (clk),
    .i_en      (bus.enable),
    .i_clr     (w_mac_clr),
    .i_acc     (w_mac_acc),
    .i_coef    (w_coef),
    .i_sample  (w_sample),
    .o_result  (w_result),
    .o_overflow(w_ovf)
  );

endmodule

// File: tb/tb_fir_tdm_filter.sv
// Bench for fir_tdm_filter: directed and random samples checked against a
// direct-form convolution model with per-channel sample histories.
module tb_fir_tdm_filter;
  localparam int WL  = 16;
  localparam int N   = 32;
  localparam int CH  = 3;
  localparam int FB  = 15;
  localparam int CHW = 2;
  localparam int LAT = N + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_tdm_filter_if #(.WORD_LENGTH(WL), .FILTER_ORDER(N), .CHANNELS(CH)) bus ();

  fir_tdm_filter #(.WORD_LENGTH(WL), .FILTER_ORDER(N), .CHANNELS(CH), .FRAC_BITS(FB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int m_act  [N];
  int m_new  [N];
  int m_hist [CH][N];

  function automatic void m_clear();
    for (int k = 0; k < N; k++) begin
      m_act[k] = 0;
      for (int c = 0; c < CH; c++) m_hist[c][k] = 0;
    end
  endfunction

  function automatic void m_push(input int c, input int x);
    for (int k = N - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
    m_hist[c][0] = x;
  endfunction

  // y = sum coef[k] * x[n-k], rounded half-up to Q0, clamped to 16-bit signed
  function automatic void m_expect(input int c, output int q, output bit ovf);
    longint acc = 0;
    longint r;
    for (int k = 0; k < N; k++) acc += longint'(m_act[k]) * longint'(m_hist[c][k]);
    r   = (acc + (longint'(1) <<< (FB - 1))) >>> FB;
    ovf = 1'b0;
    if (r > 32767) begin q = 32767; ovf = 1'b1; end
    else if (r < -32768) begin q = -32768; ovf = 1'b1; end
    else q = int'(r);
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_clear();
  endtask

  task automatic load_coefs();
    for (int k = 0; k < N; k++) begin
      bus.coef_we = 1'b1; bus.coef_addr = 5'(k); bus.coef_data = WL'(m_new[k]);
      @(negedge clk);
    end
    bus.coef_we = 1'b0; bus.coef_commit = 1'b1;
    @(negedge clk);
    bus.coef_commit = 1'b0;
    m_act = m_new;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (bus.in_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    if (bus.in_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_timeout: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic send(input int ch, input int d, output int q, output bit ovf,
                      output int och, output int lat, output bit got);
    q = 0; ovf = 1'b0; och = 0; lat = 0; got = 1'b0;
    wait_ready();
    bus.in_valid = 1'b1; bus.in_channel = CHW'(ch); bus.DataInput = WL'(d);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (bus.out_valid === 1'b1) begin
        got = 1'b1; lat = i; q = int'(bus.DataOutput); ovf = bus.overflow; och = int'(bus.out_channel);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    n_checks++; if (bus.DataOutput !== 16'sd0) begin n_fail++; $display("FAIL reset_data: got %0d required 0", bus.DataOutput); end
    n_checks++; if (bus.overflow !== 1'b0 || bus.out_channel !== 2'd0) begin n_fail++; $display("FAIL reset_ovf_ch: got %b/%0d required 0/0", bus.overflow, bus.out_channel); end
    n_checks++; if (bus.commit_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b required 0", bus.commit_pending); end
    reset = 1'b0; m_clear();
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b required 1", bus.in_ready); end
  endtask

  task automatic run_impulse(input string tag);
    int q, och, lat; bit ovf, got;
    for (int k = 0; k < N; k++) m_new[k] = 2 * (k + 1);
    load_coefs();
    for (int i = 0; i < N; i++) begin
      send(0, (i == 0) ? 16384 : 0, q, ovf, och, lat, got);
      m_push(0, (i == 0) ? 16384 : 0);
      n_checks++; if (!got || q !== i + 1) begin n_fail++; $display("FAIL %s_out[%0d]: got %0d required %0d", tag, i, q, i + 1); end
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL %s_latency[%0d]: got %0d required %0d", tag, i, lat, LAT); end
      n_checks++; if (ovf !== 1'b0 || och !== 0) begin n_fail++; $display("FAIL %s_ovf_ch[%0d]: got %b/%0d required 0/0", tag, i, ovf, och); end
    end
  endtask

  task automatic test_impulse();
    run_impulse("impulse");
  endtask

  task automatic test_channel_isolation();
    int q, och, lat; bit ovf, got;
    do_reset();
    for (int k = 0; k < N; k++) m_new[k] = 2 * (k + 1);
    load_coefs();
    for (int i = 0; i < N; i++) begin
      send(0, (i == 0) ? 16384 : 0, q, ovf, och, lat, got);
      m_push(0, (i == 0) ? 16384 : 0);
      n_checks++; if (!got || q !== i + 1 || och !== 0) begin n_fail++; $display("FAIL iso_ch0[%0d]: got %0d ch %0d required %0d ch 0", i, q, och, i + 1); end
      send(1, 0, q, ovf, och, lat, got);
      m_push(1, 0);
      n_checks++; if (!got || q !== 0 || och !== 1) begin n_fail++; $display("FAIL iso_ch1[%0d]: got %0d ch %0d required 0 ch 1", i, q, och); end
    end
  endtask

  task automatic test_saturation();
    int q, och, lat; bit ovf, got;
    do_reset();
    for (int k = 0; k < N; k++) m_new[k] = 32767;
    load_coefs();
    send(0, 32767, q, ovf, och, lat, got);
    n_checks++; if (!got || q !== 32766 || ovf !== 1'b0) begin n_fail++; $display("FAIL sat_pos_first: got %0d ovf %b required 32766 ovf 0", q, ovf); end
    send(0, 32767, q, ovf, och, lat, got);
    n_checks++; if (!got || q !== 32767 || ovf !== 1'b1) begin n_fail++; $display("FAIL sat_pos_second: got %0d ovf %b required 32767 ovf 1", q, ovf); end
    do_reset();
    load_coefs();
    send(0, -32768, q, ovf, och, lat, got);
    n_checks++; if (!got || q !== -32767 || ovf !== 1'b0) begin n_fail++; $display("FAIL sat_neg_first: got %0d ovf %b required -32767 ovf 0", q, ovf); end
    send(0, -32768, q, ovf, och, lat, got);
    n_checks++; if (!got || q !== -32768 || ovf !== 1'b1) begin n_fail++; $display("FAIL sat_neg_second: got %0d ovf %b required -32768 ovf 1", q, ovf); end
  endtask

  task automatic test_deferred_commit();
    int q, och, lat, d, e; bit ovf, got, eo;
    do_reset();
    for (int k = 0; k < N; k++) m_new[k] = rnd16() >>> 3;
    load_coefs();
    for (int i = 0; i < 3; i++) begin
      d = rnd16(); send(0, d, q, ovf, och, lat, got); m_push(0, d); m_expect(0, e, eo);
      n_checks++; if (!got || q !== e) begin n_fail++; $display("FAIL commit_warmup[%0d]: got %0d required %0d", i, q, e); end
    end
    for (int k = 0; k < N; k++) m_new[k] = rnd16() >>> 3;
    wait_ready();
    d = rnd16(); m_push(0, d); m_expect(0, e, eo);
    bus.in_valid = 1'b1; bus.in_channel = 2'd0; bus.DataInput = WL'(d);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      if (i == 16) begin
        n_checks++; if (bus.commit_pending !== 1'b0) begin n_fail++; $display("FAIL commit_early_pending: got %b required 0", bus.commit_pending); end
      end
      if (i < LAT) begin
        bus.coef_we = 1'b1; bus.coef_addr = 5'(i - 1); bus.coef_data = WL'(m_new[i-1]);
        bus.coef_commit = (i == N);
        @(negedge clk);
      end else begin
        bus.coef_we = 1'b0; bus.coef_commit = 1'b0;
        n_checks++; if (bus.commit_pending !== 1'b1) begin n_fail++; $display("FAIL commit_pending_out: got %b required 1", bus.commit_pending); end
        n_checks++; if (bus.out_valid !== 1'b1 || int'(bus.DataOutput) !== e) begin n_fail++; $display("FAIL commit_inflight_old: got %b/%0d required 1/%0d", bus.out_valid, bus.DataOutput, e); end
      end
    end
    @(negedge clk);
    n_checks++; if (bus.commit_pending !== 1'b1) begin n_fail++; $display("FAIL commit_pending_idle: got %b required 1", bus.commit_pending); end
    @(negedge clk);
    n_checks++; if (bus.commit_pending !== 1'b0) begin n_fail++; $display("FAIL commit_applied: got %b required 0", bus.commit_pending); end
    m_act = m_new;
    d = rnd16(); send(0, d, q, ovf, och, lat, got); m_push(0, d); m_expect(0, e, eo);
    n_checks++; if (!got || q !== e || ovf !== eo) begin n_fail++; $display("FAIL commit_new_bank: got %0d ovf %b required %0d ovf %b", q, ovf, e, eo); end
  endtask

  task automatic test_reset_midmac();
    int q, och, lat, d, e; bit ovf, got, eo, seen;
    for (int i = 0; i < 2; i++) begin
      d = rnd16(); send(2 * i, d, q, ovf, och, lat, got); m_push(2 * i, d); m_expect(2 * i, e, eo);
      n_checks++; if (!got || q !== e) begin n_fail++; $display("FAIL rstmac_warmup[%0d]: got %0d required %0d", i, q, e); end
    end
    wait_ready();
    bus.in_valid = 1'b1; bus.in_channel = 2'd0; bus.DataInput = WL'(rnd16());
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmac_during: got ready %b valid %b required 0 0", bus.in_ready, bus.out_valid); end
    reset = 1'b0; m_clear();
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmac_ready_after: got %b required 1", bus.in_ready); end
    seen = 1'b0;
    repeat (40) begin if (bus.out_valid === 1'b1) seen = 1'b1; @(negedge clk); end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmac_no_output: got %b required 0", seen); end
    run_impulse("rstmac_impulse");
  endtask

  task automatic test_stall();
    int d, e, lat; bit eo;
    for (int k = 0; k < N; k++) m_new[k] = rnd16() >>> 2;
    load_coefs();
    wait_ready();
    d = rnd16() >>> 2; m_push(1, d); m_expect(1, e, eo);
    bus.in_valid = 1'b1; bus.in_channel = 2'd1; bus.DataInput = WL'(d);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 5) bus.enable = 1'b0;
      if (i == 10) bus.enable = 1'b1;
      if (i == 7) begin
        n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_outputs: got ready %b valid %b required 0 0", bus.in_ready, bus.out_valid); end
      end
      if (bus.out_valid === 1'b1) begin lat = i; break; end
      @(negedge clk);
    end
    n_checks++; if (lat !== LAT + 5) begin n_fail++; $display("FAIL stall_latency: got %0d required %0d", lat, LAT + 5); end
    n_checks++; if (int'(bus.DataOutput) !== e || bus.out_channel !== 2'd1) begin n_fail++; $display("FAIL stall_value: got %0d ch %0d required %0d ch 1", bus.DataOutput, bus.out_channel, e); end
    bus.enable = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_out_gated: got %b required 0", bus.out_valid); end
    bus.enable = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b1 || int'(bus.DataOutput) !== e) begin n_fail++; $display("FAIL stall_out_represent: got %b/%0d required 1/%0d", bus.out_valid, bus.DataOutput, e); end
    @(negedge clk);
  endtask

  task automatic test_invalid_channel();
    int q, och, lat, d, e; bit ovf, got, eo, seen;
    wait_ready();
    bus.in_valid = 1'b1; bus.in_channel = 2'd3; bus.DataInput = WL'(rnd16());
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL invalid_ready: got %b required 1", bus.in_ready); end
    seen = 1'b0;
    repeat (40) begin if (bus.out_valid === 1'b1) seen = 1'b1; @(negedge clk); end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL invalid_no_output: got %b required 0", seen); end
    for (int c = 0; c < CH; c++) begin
      d = rnd16() >>> 2; send(c, d, q, ovf, och, lat, got); m_push(c, d); m_expect(c, e, eo);
      n_checks++; if (!got || q !== e || och !== c) begin n_fail++; $display("FAIL invalid_after_ch%0d: got %0d ch %0d required %0d ch %0d", c, q, och, e, c); end
    end
  endtask

  task automatic test_random();
    int q, och, lat, d, c, e; bit ovf, got, eo;
    for (int k = 0; k < N; k++) m_new[k] = rnd16() >>> $urandom_range(0, 4);
    load_coefs();
    for (int i = 0; i < 24; i++) begin
      c = int'($urandom_range(0, CH - 1));
      d = rnd16() >>> $urandom_range(0, 3);
      send(c, d, q, ovf, och, lat, got); m_push(c, d); m_expect(c, e, eo);
      n_checks++; if (!got || q !== e || ovf !== eo) begin n_fail++; $display("FAIL random_out[%0d]: got %0d ovf %b required %0d ovf %b", i, q, ovf, e, eo); end
      n_checks++; if (och !== c || lat !== LAT) begin n_fail++; $display("FAIL random_ch_lat[%0d]: got ch %0d lat %0d required ch %0d lat %0d", i, och, lat, c, LAT); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.enable = 1'b1; bus.in_valid = 1'b0; bus.in_channel = '0; bus.DataInput = '0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0; bus.coef_commit = 1'b0;
    m_clear();
    test_reset();
    test_impulse();
    test_channel_isolation();
    test_saturation();
    test_deferred_commit();
    test_reset_midmac();
    test_stall();
    test_invalid_channel();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
